// File: rtl/md_pkg.sv
// Shared definitions for the multdiv sequencer:
// FSM state encoding and rstatus exception codes.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int RSTATUS_MULT    = 4;
  localparam int RSTATUS_DIV     = 5;
  localparam int RSTATUS_REG_DEF = 30;

endpackage

// File: rtl/md_hazard_check.sv
// Combinational F/D hazard compare against the
// register owned by the in-flight multdiv op.
module md_hazard_check
  import md_pkg::*;
#(
  parameter int REG_BITS    = 5,
  parameter int RSTATUS_REG = RSTATUS_REG_DEF
) (
  input  logic                active,
  input  logic [REG_BITS-1:0] busy_rd,
  input  logic [REG_BITS-1:0] fd_rs,
  input  logic [REG_BITS-1:0] fd_rt,
  input  logic [REG_BITS-1:0] fd_rd,
  input  logic                fd_we,
  input  logic                fd_is_md,
  output logic                stall
);

  localparam logic [REG_BITS-1:0] RS_REG =
    REG_BITS'(RSTATUS_REG);

  logic tracked;
  logic raw_waw;
  logic rstat;

  assign tracked = busy_rd != '0;

  assign raw_waw = tracked &
    ((fd_rs == busy_rd) |
     (fd_rt == busy_rd) |
     (fd_we & (fd_rd == busy_rd)));

  // An exception may land in rstatus, so its readers wait too.
  assign rstat = (fd_rs == RS_REG) | (fd_rt == RS_REG);

  assign stall = active & (fd_is_md | raw_waw | rstat);

endmodule

// File: rtl/multdiv_sequencer.sv
// Issue/complete sequencer for the shared multdiv unit:
// start pulses, hazard stall, write-port arbitration.
module multdiv_sequencer
  import md_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_BITS    = 5,
  parameter int TIMEOUT     = 40,
  parameter int RSTATUS_REG = RSTATUS_REG_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_mult,
  input  logic                issue_div,
  input  logic [REG_BITS-1:0] issue_rd,
  output logic                md_ctrl_mult,
  output logic                md_ctrl_div,
  input  logic                md_result_rdy,
  input  logic                md_exception,
  input  logic [DATA_W-1:0]   md_result,
  input  logic                pipe_we,
  input  logic [REG_BITS-1:0] pipe_wr_reg,
  input  logic [DATA_W-1:0]   pipe_wr_data,
  input  logic [REG_BITS-1:0] fd_rs,
  input  logic [REG_BITS-1:0] fd_rt,
  input  logic [REG_BITS-1:0] fd_rd,
  input  logic                fd_we,
  input  logic                fd_is_md,
  output logic                wb_we,
  output logic [REG_BITS-1:0] wb_reg,
  output logic [DATA_W-1:0]   wb_data,
  output logic                stall,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [REG_BITS-1:0] busy_rd;
  logic                is_div;
  logic                pend_we;
  logic [REG_BITS-1:0] pend_reg;
  logic [DATA_W-1:0]   pend_data;

  logic                issue;
  logic                timeout;
  logic                done;
  logic                exc;
  logic                res_we;
  logic [REG_BITS-1:0] res_reg;
  logic [DATA_W-1:0]   res_data;
  logic                md_fin;
  logic                md_we;
  logic [REG_BITS-1:0] md_reg;
  logic [DATA_W-1:0]   md_data;
  logic                hz_active;

  assign issue   = issue_mult | issue_div;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign done    = (state == RUN) &
                   (md_result_rdy | timeout);

  // A timeout without a result is reported as an exception.
  assign exc = md_result_rdy ? md_exception : 1'b1;

  assign res_reg  = exc ? REG_BITS'(RSTATUS_REG) : busy_rd;
  assign res_data = exc ?
    (is_div ? DATA_W'(RSTATUS_DIV) :
              DATA_W'(RSTATUS_MULT)) :
    md_result;
  assign res_we   = exc | (busy_rd != '0);

  assign md_fin = ~pipe_we &
    (done | (state == PEND));

  assign md_we   = md_fin & ~reset &
                   ((state == PEND) ? pend_we : res_we);
  assign md_reg  = (state == PEND) ? pend_reg : res_reg;
  assign md_data = (state == PEND) ? pend_data : res_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_rd   <= '0;
      is_div    <= 1'b0;
      pend_we   <= 1'b0;
      pend_reg  <= '0;
      pend_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && issue) begin
        busy_rd <= issue_rd;
        is_div  <= issue_div;
        cnt     <= '0;
      end
      if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (done && pipe_we) begin
          pend_we   <= res_we;
          pend_reg  <= res_reg;
          pend_data <= res_data;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = RUN;
      RUN: begin
        if (done) state_nxt = pipe_we ? PEND : IDLE;
      end
      PEND: if (!pipe_we) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    if (state == IDLE && !reset) begin
      md_ctrl_mult = issue_mult & ~issue_div;
      md_ctrl_div  = issue_div;
    end
    wb_we   = 1'b0;
    wb_reg  = '0;
    wb_data = '0;
    if (pipe_we) begin
      wb_we   = 1'b1;
      wb_reg  = pipe_wr_reg;
      wb_data = pipe_wr_data;
    end else if (md_we) begin
      wb_we   = 1'b1;
      wb_reg  = md_reg;
      wb_data = md_data;
    end
  end

  assign busy = state != IDLE;

  // Regfile is write-before-read, so the write cycle itself is safe.
  assign hz_active = busy & ~md_fin & ~reset;

  md_hazard_check #(
    .REG_BITS    (REG_BITS),
    .RSTATUS_REG (RSTATUS_REG)
  ) u_hazard (
    .active   (hz_active),
    .busy_rd  (busy_rd),
    .fd_rs    (fd_rs),
    .fd_rt    (fd_rt),
    .fd_rd    (fd_rd),
    .fd_we    (fd_we),
    .fd_is_md (fd_is_md),
    .stall    (stall)
  );

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: transaction-level model of each mult/div op
// predicts every cycle's outputs; a monitor compares them.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_mult = 1'b0;
  logic        issue_div = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        md_result_rdy = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = '0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wr_reg = '0;
  logic [31:0] pipe_wr_data = '0;
  logic [4:0]  fd_rs = '0;
  logic [4:0]  fd_rt = '0;
  logic [4:0]  fd_rd = '0;
  logic        fd_we = 1'b0;
  logic        fd_is_md = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        st;
    logic        bz;
    logic        cm;
    logic        cd;
  } exp_t;

  exp_t q[$];

  multdiv_sequencer #(
    .DATA_W(32), .REG_BITS(5),
    .TIMEOUT(TIMEOUT), .RSTATUS_REG(30)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_mult(issue_mult), .issue_div(issue_div),
    .issue_rd(issue_rd),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result_rdy(md_result_rdy),
    .md_exception(md_exception), .md_result(md_result),
    .pipe_we(pipe_we), .pipe_wr_reg(pipe_wr_reg),
    .pipe_wr_data(pipe_wr_data),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .fd_we(fd_we), .fd_is_md(fd_is_md),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    exp_t e;
    exp_t g;
    if (q.size() != 0) begin
      e = q.pop_front();
      g = '{we: wb_we, rg: wb_reg, d: wb_data, st: stall,
            bz: busy, cm: md_ctrl_mult, cd: md_ctrl_div};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL cycle_out t=%0t got we=%b reg=%0d data=%h stall=%b busy=%b cm=%b cd=%b want we=%b reg=%0d data=%h stall=%b busy=%b cm=%b cd=%b",
          $time, g.we, g.rg, g.d, g.st, g.bz, g.cm, g.cd,
          e.we, e.rg, e.d, e.st, e.bz, e.cm, e.cd);
      end
    end
  end

  function automatic bit hz(input logic [4:0] t);
    return fd_is_md ||
      (t != 0 && (fd_rs == t || fd_rt == t ||
                  (fd_we && fd_rd == t))) ||
      fd_rs == 5'd30 || fd_rt == 5'd30;
  endfunction

  function automatic logic [4:0] pick(input logic [4:0] t);
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return t;
    if (r == 1) return 5'd30;
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_fd(input logic [4:0] t);
    fd_rs    = pick(t);
    fd_rt    = pick(t);
    fd_rd    = pick(t);
    fd_we    = 1'($urandom);
    fd_is_md = $urandom_range(0, 5) == 0;
  endtask

  task automatic rand_pipe(input bit force_we);
    pipe_we      = force_we || ($urandom_range(0, 3) == 0);
    pipe_wr_reg  = 5'($urandom);
    pipe_wr_data = $urandom;
  endtask

  // Push this cycle's expectation, then advance to posedge+1.
  task automatic tick(input bit bz, input bit cm, input bit cd,
                      input bit st, input bit mw,
                      input logic [4:0] mr, input logic [31:0] mdv);
    exp_t e;
    e.bz = bz; e.cm = cm; e.cd = cd; e.st = st;
    if (pipe_we) begin
      e.we = 1'b1; e.rg = pipe_wr_reg; e.d = pipe_wr_data;
    end else if (mw) begin
      e.we = 1'b1; e.rg = mr; e.d = mdv;
    end else begin
      e.we = 1'b0; e.rg = '0; e.d = '0;
    end
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      issue_mult    = 1'b0;
      issue_div     = 1'b0;
      md_result_rdy = $urandom_range(0, 2) == 0;
      md_exception  = 1'($urandom);
      md_result     = $urandom;
      rand_pipe(1'b0);
      rand_fd(5'($urandom));
      tick(0, 0, 0, 0, 0, '0, '0);
    end
  endtask

  // lat=0: unit never answers; pb: cycles pipe_we holds from completion;
  // rst_at: RUN/PEND cycle that asserts reset (0 = none).
  task automatic op(input bit dv, input bit both,
                    input logic [4:0] rd, input int lat,
                    input bit ex, input logic [31:0] res,
                    input int pb, input int rst_at);
    int done_t;
    int wr_t;
    bit xe;
    bit mw;
    bit stop;
    logic [4:0] mr;
    logic [31:0] mdv;
    done_t = (lat == 0) ? TIMEOUT : lat;
    wr_t   = done_t + pb;
    xe     = (lat == 0) || ex;
    mr     = xe ? 5'd30 : rd;
    mdv    = xe ? (dv ? 32'd5 : 32'd4) : res;
    mw     = xe || (rd != 0);
    stop   = 1'b0;
    issue_mult    = !dv || both;
    issue_div     = dv;
    issue_rd      = rd;
    md_result_rdy = 1'b0;
    rand_pipe(1'b0);
    rand_fd(5'($urandom));
    tick(0, !dv, dv, 0, 0, '0, '0);
    for (int t = 1; t <= wr_t && !stop; t++) begin
      issue_mult    = $urandom_range(0, 3) == 0;
      issue_div     = $urandom_range(0, 3) == 0;
      issue_rd      = 5'($urandom);
      md_result_rdy = (lat != 0) && (t == lat);
      md_exception  = md_result_rdy ? ex : 1'($urandom);
      md_result     = md_result_rdy ? res : $urandom;
      if (t < done_t) rand_pipe(1'b0);
      else if (t < wr_t) rand_pipe(1'b1);
      else pipe_we = 1'b0;
      rand_fd(rd);
      if (t == rst_at) begin
        reset   = 1'b1;
        pipe_we = 1'b0;
        tick(1, 0, 0, 0, 0, '0, '0);
        reset = 1'b0;
        stop  = 1'b1;
      end else begin
        tick(1, 0, 0, (t == wr_t) ? 1'b0 : hz(rd),
             t == wr_t && mw, mr, mdv);
      end
    end
    issue_mult = 1'b0;
    issue_div  = 1'b0;
  endtask

  initial begin
    int lat;
    int pb;
    int dt;
    int ra;
    @(posedge clock);
    @(posedge clock);
    #1;
    tick(0, 0, 0, 0, 0, '0, '0);
    reset = 1'b0;
    idle(2);
    op(0, 0, 5'd7, 33, 0, 32'h30, 0, 0);
    idle(1);
    op(0, 0, 5'd7, 12, 0, 32'hdead_beef, 3, 0);
    op(1, 0, 5'd9, 15, 1, 32'h1234, 0, 0);
    op(0, 0, 5'd9, 8, 1, 32'h1234, 0, 0);
    op(1, 0, 5'd9, 0, 0, 32'h0, 0, 0);
    idle(3);
    op(0, 0, 5'd0, 6, 0, 32'h55, 0, 0);
    op(0, 0, 5'd0, 6, 1, 32'h55, 2, 0);
    op(1, 1, 5'd12, 20, 0, 32'hcafe, 1, 0);
    op(0, 0, 5'd3, 20, 0, 32'h77, 0, 5);
    op(1, 0, 5'd3, 10, 0, 32'h77, 4, 12);
    op(0, 0, 5'd5, 4, 0, 32'h99, 0, 0);
    op(1, 0, 5'd6, 0, 0, 32'h0, 3, 0);
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(0, TIMEOUT - 1);
      pb  = $urandom_range(0, 4);
      dt  = (lat == 0) ? TIMEOUT : lat;
      ra  = 0;
      if ($urandom_range(0, 5) == 0) begin
        if (pb >= 2) ra = $urandom_range(dt + 1, dt + pb - 1);
        else if (dt > 1) ra = $urandom_range(1, dt - 1);
      end
      op(1'($urandom), 1'($urandom), 5'($urandom), lat,
         1'($urandom), $urandom, pb, ra);
      idle($urandom_range(0, 3));
    end
    idle(2);
    @(negedge clock);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain left=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
